dmem_arbiter: RTL and testbench

// - Shares the single byte-wide data RAM between two requesters.
//   - Requester 1: the pipeline memory stage (cpu port).
//   - Requester 2: an external loader/debug port (ext port, valid/ready).
// - Sits between the memory stage and the data RAM instance and drives all RAM inputs.
// - Default policy: the cpu has fixed priority. An optional starvation guard forces periodic ext slots.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_wait_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package dmem_arb_pkg;

   localparam int unsigned DMEM_AW = 14;
   localparam int unsigned DMEM_DW = 8;

   typedef enum logic [1:0] {IDLE, CPU, EXT, FORCE_EXT} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of consecutive denied ext cycles; trip_c fires on the denial
// that reaches MAX_WAIT and the count restarts from zero.
module dmem_wait_counter #(
   parameter int unsigned MAX_WAIT = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic trip_c
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt;

   assign trip_c = inc && (cnt == CW'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || trip_c) begin
         cnt <= '0;
      end else if (inc && (cnt < CW'(MAX_WAIT))) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the byte-wide data RAM between the cpu memory stage (fixed priority) and
// an ext valid/ready port. DMEM_ARB_STARVE_GUARD_EN adds a forced ext slot after MAX_WAIT denials.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = DMEM_AW,
   parameter int unsigned DW       = DMEM_DW,
   parameter int unsigned MAX_WAIT = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ext_valid,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   output logic          ext_ready,
   output logic [DW-1:0] ext_rdata,
   output logic          ext_rvalid,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q
);

   arb_state_t    state;
   owner_t        owner;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          xfer;
   logic          force_slot;
   logic          trip;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   assign force_slot = (state == FORCE_EXT);
   assign cpu_stall  = cpu_req && (owner != OWN_CPU);

   dmem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .inc    (ext_valid && !ext_ready),
      .clr    (xfer || !ext_valid),
      .trip_c (trip)
   );
`else
   assign force_slot = 1'b0;
   assign cpu_stall  = 1'b0;
   assign trip       = 1'b0;
`endif

   // Owner is withheld while reset is low so nothing reaches the RAM.
   always_comb begin
      owner = OWN_NONE;
      if (!reset)          owner = OWN_NONE;
      else if (force_slot) owner = OWN_EXT;
      else if (cpu_req)    owner = OWN_CPU;
      else if (ext_valid)  owner = OWN_EXT;
   end

   // RAM mux; an idle cycle re-drives the last address/data with writes off.
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = 1'b0;
      case (owner)
         OWN_CPU: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
         end
         OWN_EXT: begin
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
            ram_we    = ext_we && ext_valid;
         end
         default: ;
      endcase
   end

   assign ext_ready = (owner == OWN_EXT);
   assign xfer      = ext_valid && ext_ready;
   assign cpu_rdata = ram_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         addr_q     <= ram_addr;
         wdata_q    <= ram_wdata;
         ext_rvalid <= xfer && !ext_we;
         if (xfer && !ext_we) ext_rdata <= ram_q;
         if (trip) begin
            state <= FORCE_EXT;
         end else begin
            case (owner)
               OWN_CPU: state <= CPU;
               OWN_EXT: state <= EXT;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

   localparam int unsigned AW       = 14;
   localparam int unsigned DW       = 8;
   localparam int unsigned MAX_WAIT = 7;
   localparam int          DEPTH    = 1 << AW;
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          ext_valid = 1'b0, ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic          ext_ready;
   logic [DW-1:0] ext_rdata;
   logic          ext_rvalid;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_ready(ext_ready), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
   );

   function automatic logic [7:0] init_val(input int a);
      case (a)
         'h10:    return 8'hA5;
         'h01:    return 8'h11;
         'h02:    return 8'h22;
         'h03:    return 8'h33;
         default: return 8'(a * 7 + 3);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Data RAM: preloads on its first falling edge, then writes/reads on each falling edge.
   logic [7:0] mem [0:DEPTH-1];
   bit         mem_ready = 1'b0;
   always @(negedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
         mem_ready = 1'b1;
         ram_q <= '0;
      end else begin
         if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
         ram_q <= (ram_we === 1'b1) ? ram_wdata : mem[ram_addr];
      end
   end

   // Reference model and per-cycle compare, 3 time units after each rising edge.
   logic [7:0]    shadow [0:DEPTH-1];
   int            streak;
   bit            forced, exp_rvalid, nxt_rvalid;
   logic [7:0]    exp_rdata;
   logic [AW-1:0] last_addr, e_addr;
   logic [7:0]    last_wdata, e_wd;
   logic          e_we;
   int            own;

   initial begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
      streak = 0; forced = 0; exp_rvalid = 0; exp_rdata = '0;
      last_addr = '0; last_wdata = '0;
      forever begin
         @(posedge clk);
         #3;
         if (!reset) begin
            streak = 0; forced = 0; exp_rvalid = 0; exp_rdata = '0;
            last_addr = '0; last_wdata = '0;
            check("rst_rvalid", ext_rvalid, 0);
            check("rst_rdata", ext_rdata, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ready", ext_ready, 0);
            check("rst_stall", cpu_stall, GUARD ? cpu_req : 1'b0);
         end else begin
            own    = forced ? 2 : (cpu_req ? 1 : (ext_valid ? 2 : 0));
            e_addr = (own == 1) ? cpu_addr  : (own == 2) ? ext_addr  : last_addr;
            e_wd   = (own == 1) ? cpu_wdata : (own == 2) ? ext_wdata : last_wdata;
            e_we   = (own == 1) ? cpu_we    : (own == 2) ? (ext_we & ext_valid) : 1'b0;
            check("ext_ready", ext_ready, own == 2);
            check("cpu_stall", cpu_stall, GUARD && cpu_req && own != 1);
            check("ram_we", ram_we, e_we);
            check("ram_addr", ram_addr, e_addr);
            check("ram_wdata", ram_wdata, e_wd);
            check("cpu_rdata", cpu_rdata, ram_q);
            check("ext_rvalid", ext_rvalid, exp_rvalid);
            if (exp_rvalid) check("ext_rdata", ext_rdata, exp_rdata);
            nxt_rvalid = (own == 2) && ext_valid && !ext_we;
            if (nxt_rvalid) exp_rdata = shadow[ext_addr];
            if (e_we) shadow[e_addr] = e_wd;
            last_addr  = e_addr;
            last_wdata = e_wd;
            forced     = 0;
            if (GUARD) begin
               if (ext_valid && own != 2) begin
                  streak++;
                  if (streak >= int'(MAX_WAIT)) begin
                     forced = 1;
                     streak = 0;
                  end
               end else begin
                  streak = 0;
               end
            end
            exp_rvalid = nxt_rvalid;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic req, input logic we, input int a, input int d);
      cpu_req = req; cpu_we = we; cpu_addr = AW'(a); cpu_wdata = DW'(d);
   endtask

   task automatic set_ext(input logic v, input logic we, input int a, input int d);
      ext_valid = v; ext_we = we; ext_addr = AW'(a); ext_wdata = DW'(d);
   endtask

   bit pend;

   initial begin
      repeat (3) next_cycle();
      reset = 1'b1;
      next_cycle();

      // ext-only read of a preloaded byte
      next_cycle(); set_cpu(0, 0, 0, 0); set_ext(1, 0, 'h10, 0); #3;
      check("t1_ready", ext_ready, 1);
      next_cycle(); set_ext(0, 0, 0, 0); #3;
      check("t1_rvalid", ext_rvalid, 1);
      check("t1_rdata", ext_rdata, 8'hA5);
      next_cycle(); #3;
      check("t1_rvalid_once", ext_rvalid, 0);

      // collision: cpu write wins, ext read follows and sees the new byte
      next_cycle(); set_cpu(1, 1, 'h20, 'h3C); set_ext(1, 0, 'h20, 0); #3;
      check("t2_ready", ext_ready, 0);
      check("t2_stall", cpu_stall, 0);
      check("t2_we", ram_we, 1);
      next_cycle(); set_cpu(0, 0, 0, 0); #3;
      check("t2_accept", ext_ready, 1);
      next_cycle(); set_ext(0, 0, 0, 0); #3;
      check("t2_rdata", ext_rdata, 8'h3C);

      // starvation: both requesting continuously
      for (int i = 1; i <= (GUARD ? 9 : 50); i++) begin
         next_cycle(); set_cpu(1, 0, 5, 0); set_ext(1, 0, 'h10, 0); #3;
         check("t3_ready", ext_ready, GUARD && i == 8);
         check("t3_stall", cpu_stall, GUARD && i == 8);
      end
      next_cycle(); set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0);

      // reset right after a read transfer drops the response
      next_cycle(); set_ext(1, 0, 2, 0); #3;
      check("t4_ready", ext_ready, 1);
      next_cycle(); reset = 1'b0; set_cpu(1, 1, 'h30, 'h77); set_ext(0, 0, 0, 0); #3;
      check("t4_rvalid", ext_rvalid, 0);
      check("t4_rdata", ext_rdata, 0);
      check("t4_we", ram_we, 0);
      next_cycle(); reset = 1'b1; set_cpu(0, 0, 0, 0); set_ext(1, 0, 3, 0); #3;
      check("t4_idle_ready", ext_ready, 1);
      next_cycle(); set_ext(0, 0, 0, 0); #3;
      check("t4_rdata_after", ext_rdata, 8'h33);

      // back-to-back ext reads
      next_cycle(); set_ext(1, 0, 1, 0); #3;
      next_cycle(); set_ext(1, 0, 2, 0); #3;
      check("t5_rv1", ext_rvalid, 1);
      check("t5_rd1", ext_rdata, 8'h11);
      next_cycle(); set_ext(1, 0, 3, 0); #3;
      check("t5_rv2", ext_rvalid, 1);
      check("t5_rd2", ext_rdata, 8'h22);
      next_cycle(); set_ext(0, 0, 0, 0); #3;
      check("t5_rv3", ext_rvalid, 1);
      check("t5_rd3", ext_rdata, 8'h33);
      next_cycle(); #3;
      check("t5_rv_end", ext_rvalid, 0);

      // randomized traffic with occasional resets; ext holds its request until accepted
      pend = 0;
      for (int c = 0; c < 4000; c++) begin
         next_cycle();
         reset = ($urandom_range(0, 199) != 0);
         set_cpu($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
         if (!pend && $urandom_range(0, 1) == 1) begin
            pend = 1;
            set_ext(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 255)));
         end
         ext_valid = pend;
         #3;
         if (pend && ext_ready) pend = 0;
      end
      next_cycle(); reset = 1'b1; set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0);
      repeat (3) next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
